// File: rtl/noc_flit_depacketizer_pkg.sv
// Flit field layout, marker codes, receive FSM states and helpers shared by
// the depacketizer and its payload FIFO.
package noc_flit_depacketizer_pkg;

  localparam int NOC_DATA_WIDTH = 32;
  localparam int NOC_ID_X_WIDTH = 4;
  localparam int NOC_ID_Y_WIDTH = 4;
  localparam int AXI_LEN_BIT    = 8;
  localparam int NOC_MARK_WIDTH = 2;

  // Header / tail layout, MSB first:
  // [31:30] H marker | [29:26] src X | [25:22] src Y | [21:18] dst X |
  // [17:14] dst Y | [13:12] TYPE | [11:10] ORDER | [9:2] LEN | [1:0] E marker
  localparam int NOC_POINT_H      = NOC_DATA_WIDTH - NOC_MARK_WIDTH;
  localparam int NOC_SOURCE_POINT = NOC_POINT_H - 1;
  localparam int NOC_SRC_X_LSB    = NOC_SOURCE_POINT - NOC_ID_X_WIDTH + 1;
  localparam int NOC_SRC_Y_LSB    = NOC_SRC_X_LSB - NOC_ID_Y_WIDTH;
  localparam int NOC_DST_X_LSB    = NOC_SRC_Y_LSB - NOC_ID_X_WIDTH;
  localparam int NOC_DST_Y_LSB    = NOC_DST_X_LSB - NOC_ID_Y_WIDTH;
  localparam int NOC_TYPE_LSB     = NOC_DST_Y_LSB - 2;
  localparam int NOC_ORDER_LSB    = NOC_TYPE_LSB - 2;
  localparam int AXI_LEN_POINT    = NOC_ORDER_LSB - AXI_LEN_BIT;
  localparam int NOC_POINT_E      = 0;

  localparam logic [NOC_MARK_WIDTH-1:0] NOC_HEAD_H = 2'b10;
  localparam logic [NOC_MARK_WIDTH-1:0] NOC_HEAD_E = 2'b01;
  localparam logic [NOC_MARK_WIDTH-1:0] NOC_TAIL_H = 2'b01;
  localparam logic [NOC_MARK_WIDTH-1:0] NOC_TAIL_E = 2'b10;

  typedef enum logic [0:0] {
    NOC_RX_WAIT_HDR = 1'b0,
    NOC_RX_PAYLOAD  = 1'b1
  } noc_rx_state_e;

  // One queued payload beat, tagged with its packet's source and last flag.
  typedef struct packed {
    logic [NOC_DATA_WIDTH-1:0] data;
    logic [NOC_ID_X_WIDTH-1:0] src_x;
    logic [NOC_ID_Y_WIDTH-1:0] src_y;
    logic                      last;
  } noc_beat_t;

  localparam int NOC_BEAT_WIDTH = $bits(noc_beat_t);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/noc_flit_depacketizer_sync_fifo.sv
// Single-clock FIFO for payload beats. Push is ignored when full and pop when
// empty; pointers wrap naturally because DEPTH is a power of two.
module noc_flit_depacketizer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             noc_clk,
  input  logic             noc_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next pointer, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset clears storage so outputs read 0.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/noc_flit_depacketizer.sv
// Receive-side NoC endpoint: validates header/tail framing and routing,
// queues payload beats for the local consumer, reports per-packet status.
module noc_flit_depacketizer
  import noc_flit_depacketizer_pkg::*;
#(
  parameter logic [NOC_ID_X_WIDTH-1:0] X_ID       = '0,
  parameter logic [NOC_ID_Y_WIDTH-1:0] Y_ID       = '0,
  parameter int                        FIFO_DEPTH = 4
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  input  logic [NOC_DATA_WIDTH-1:0] rx_flit,
  input  logic                      rx_is_header,
  input  logic                      rx_is_tail,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NOC_DATA_WIDTH-1:0] out_data,
  output logic [NOC_ID_X_WIDTH-1:0] out_src_x,
  output logic [NOC_ID_Y_WIDTH-1:0] out_src_y,
  output logic                      out_last,
  output logic                      pkt_done,
  output logic                      pkt_ok,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               err_cnt
);

  noc_rx_state_e            state_q, state_d;
  logic [NOC_ID_X_WIDTH-1:0] src_x_q, src_x_d;
  logic [NOC_ID_Y_WIDTH-1:0] src_y_q, src_y_d;
  logic [AXI_LEN_BIT-1:0]    len_q, len_d;
  // One bit wider than LEN so LEN+1 and overlength counts are representable.
  logic [AXI_LEN_BIT:0]      beat_cnt_q, beat_cnt_d;
  logic                      err_q, err_d;
  logic                      pkt_done_q, pkt_done_d;
  logic                      pkt_ok_q, pkt_ok_d;
  logic [15:0]               pkt_cnt_q, pkt_cnt_d;
  logic [15:0]               err_cnt_q, err_cnt_d;

  logic                      accept;
  logic                      load_hdr;
  logic                      hdr_good;
  logic                      tail_bad;
  logic [NOC_MARK_WIDTH-1:0] mark_h;
  logic [NOC_MARK_WIDTH-1:0] mark_e;
  logic [NOC_ID_X_WIDTH-1:0] flit_src_x;
  logic [NOC_ID_Y_WIDTH-1:0] flit_src_y;
  logic [NOC_ID_X_WIDTH-1:0] flit_dst_x;
  logic [NOC_ID_Y_WIDTH-1:0] flit_dst_y;
  logic [AXI_LEN_BIT-1:0]    flit_len;

  logic      fifo_push;
  logic      fifo_full;
  logic      fifo_empty;
  noc_beat_t fifo_wdata;
  noc_beat_t fifo_rdata;

  assign mark_h     = rx_flit[NOC_POINT_H +: NOC_MARK_WIDTH];
  assign mark_e     = rx_flit[NOC_POINT_E +: NOC_MARK_WIDTH];
  assign flit_src_x = rx_flit[NOC_SRC_X_LSB +: NOC_ID_X_WIDTH];
  assign flit_src_y = rx_flit[NOC_SRC_Y_LSB +: NOC_ID_Y_WIDTH];
  assign flit_dst_x = rx_flit[NOC_DST_X_LSB +: NOC_ID_X_WIDTH];
  assign flit_dst_y = rx_flit[NOC_DST_Y_LSB +: NOC_ID_Y_WIDTH];
  assign flit_len   = rx_flit[AXI_LEN_POINT +: AXI_LEN_BIT];

  // A flit flagged both header and tail never counts as a good header.
  assign hdr_good = rx_is_header & ~rx_is_tail &
                    (mark_h == NOC_HEAD_H) & (mark_e == NOC_HEAD_E);

  // Tails never push, so they are accepted even with the FIFO full.
  assign rx_ready = (state_q == NOC_RX_WAIT_HDR) | ~fifo_full | rx_is_tail;
  assign accept   = rx_valid & rx_ready;

  assign tail_bad = err_q | (mark_h != NOC_TAIL_H) | (mark_e != NOC_TAIL_E) |
                    (flit_src_x != src_x_q) | (flit_src_y != src_y_q) |
                    (beat_cnt_q != ({1'b0, len_q} + 1'b1));

  // Packet framing FSM, beat tagging and status/counter updates.
  always_comb begin
    state_d    = state_q;
    src_x_d    = src_x_q;
    src_y_d    = src_y_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    pkt_done_d = 1'b0;
    pkt_ok_d   = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    load_hdr   = 1'b0;
    fifo_push  = 1'b0;
    fifo_wdata = '{data: rx_flit, src_x: src_x_q, src_y: src_y_q,
                   last: (beat_cnt_q == {1'b0, len_q})};

    case (state_q)
      NOC_RX_WAIT_HDR: begin
        if (accept && hdr_good) load_hdr = 1'b1;
      end
      NOC_RX_PAYLOAD: begin
        if (accept) begin
          if (rx_is_header) begin
            // Tail lost or header/tail conflict: abort the open packet.
            pkt_done_d = 1'b1;
            err_cnt_d  = sat_inc16(err_cnt_q);
            if (hdr_good) load_hdr = 1'b1;
            else          state_d  = NOC_RX_WAIT_HDR;
          end else if (rx_is_tail) begin
            pkt_done_d = 1'b1;
            pkt_ok_d   = ~tail_bad;
            if (tail_bad) err_cnt_d = sat_inc16(err_cnt_q);
            else          pkt_cnt_d = pkt_cnt_q + 16'd1;
            state_d = NOC_RX_WAIT_HDR;
          end else begin
            if (beat_cnt_q <= {1'b0, len_q}) fifo_push = 1'b1;
            else                             err_d     = 1'b1;
            if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = NOC_RX_WAIT_HDR;
    endcase

    if (load_hdr) begin
      src_x_d    = flit_src_x;
      src_y_d    = flit_src_y;
      len_d      = flit_len;
      beat_cnt_d = '0;
      err_d      = (flit_dst_x != X_ID) | (flit_dst_y != Y_ID);
      state_d    = NOC_RX_PAYLOAD;
    end
  end

  // FSM and status registers.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q    <= NOC_RX_WAIT_HDR;
      src_x_q    <= '0;
      src_y_q    <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_ok_q   <= 1'b0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      pkt_done_q <= pkt_done_d;
      pkt_ok_q   <= pkt_ok_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  noc_flit_depacketizer_sync_fifo #(
    .WIDTH (NOC_BEAT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .push      (fifo_push),
    .wdata     (fifo_wdata),
    .full      (fifo_full),
    .pop       (out_ready),
    .rdata     (fifo_rdata),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_rdata.data;
  assign out_src_x = fifo_rdata.src_x;
  assign out_src_y = fifo_rdata.src_y;
  assign out_last  = fifo_rdata.last;
  assign pkt_done  = pkt_done_q;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_noc_flit_depacketizer.sv
// Directed bench for the NoC flit depacketizer (node X=1, Y=2, 4-entry FIFO).
module tb_noc_flit_depacketizer;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_flit;
  logic        rx_is_header;
  logic        rx_is_tail;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_src_x;
  logic [3:0]  out_src_y;
  logic        out_last;
  logic        pkt_done;
  logic        pkt_ok;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;
  logic [40:0] beat_q [$];

  noc_flit_depacketizer #(
    .X_ID       (4'd1),
    .Y_ID       (4'd2),
    .FIFO_DEPTH (4)
  ) dut (
    .noc_clk      (noc_clk),
    .noc_rst_n    (noc_rst_n),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_flit      (rx_flit),
    .rx_is_header (rx_is_header),
    .rx_is_tail   (rx_is_tail),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_src_x    (out_src_x),
    .out_src_y    (out_src_y),
    .out_last     (out_last),
    .pkt_done     (pkt_done),
    .pkt_ok       (pkt_ok),
    .pkt_cnt      (pkt_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 noc_clk = ~noc_clk;

  // Record every beat the consumer takes; inputs only change just after posedge.
  always @(negedge noc_clk) begin
    if (noc_rst_n && out_valid && out_ready)
      beat_q.push_back({out_data, out_src_x, out_src_y, out_last});
  end

  function automatic logic [31:0] mk_hdr(input logic [3:0] sx, input logic [3:0] sy,
                                         input logic [3:0] dx, input logic [3:0] dy,
                                         input logic [7:0] len);
    return {2'b10, sx, sy, dx, dy, 2'b00, 2'b00, len, 2'b01};
  endfunction

  function automatic logic [31:0] mk_tail(input logic [3:0] sx, input logic [3:0] sy);
    return {2'b01, sx, sy, 4'h0, 4'h0, 2'b00, 2'b00, 8'h00, 2'b10};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge noc_clk);
      #1;
    end
  endtask

  // Present one flit, wait (bounded) for rx_ready, let it be accepted.
  task automatic send(input logic [31:0] flit, input logic hdr, input logic tail);
    int n;
    rx_valid     = 1'b1;
    rx_flit      = flit;
    rx_is_header = hdr;
    rx_is_tail   = tail;
    #1;
    n = 0;
    while (!rx_ready && n < 64) begin
      cyc();
      n++;
    end
    chk("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
    cyc();
    rx_valid     = 1'b0;
    rx_is_header = 1'b0;
    rx_is_tail   = 1'b0;
    rx_flit      = '0;
  endtask

  function automatic logic [40:0] pop_beat();
    if (beat_q.size() > 0) return beat_q.pop_front();
    return 'x;
  endfunction

  initial begin
    noc_rst_n    = 1'b0;
    rx_valid     = 1'b0;
    rx_flit      = '0;
    rx_is_header = 1'b0;
    rx_is_tail   = 1'b0;
    out_ready    = 1'b1;
    cyc(3);
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_pkt_done", {63'd0, pkt_done}, 64'd0);
    chk("rst_counters", {32'd0, pkt_cnt, err_cnt}, 64'd0);
    noc_rst_n = 1'b1;
    cyc(2);

    // 1: good single-beat packet.
    send(mk_hdr(4'd0, 4'd0, 4'd1, 4'd2, 8'd0), 1'b1, 1'b0);
    send(32'hDEADBEEF, 1'b0, 1'b0);
    chk("t1_latency_out_valid", {63'd0, out_valid}, 64'd1);
    send(mk_tail(4'd0, 4'd0), 1'b0, 1'b1);
    chk("t1_done_ok", {62'd0, pkt_done, pkt_ok}, 64'd3);
    chk("t1_counters", {32'd0, pkt_cnt, err_cnt}, {32'd0, 16'd1, 16'd0});
    cyc(3);
    chk("t1_pulse_gone", {63'd0, pkt_done}, 64'd0);
    chk("t1_beat_count", beat_q.size(), 64'd1);
    chk("t1_beat", {23'd0, pop_beat()}, {23'd0, 32'hDEADBEEF, 4'd0, 4'd0, 1'b1});

    // 2: misrouted packet still delivers its beat but is flagged bad.
    send(mk_hdr(4'd0, 4'd0, 4'd3, 4'd3, 8'd0), 1'b1, 1'b0);
    send(32'h12345678, 1'b0, 1'b0);
    send(mk_tail(4'd0, 4'd0), 1'b0, 1'b1);
    chk("t2_done_ok", {62'd0, pkt_done, pkt_ok}, 64'd2);
    chk("t2_counters", {32'd0, pkt_cnt, err_cnt}, {32'd0, 16'd1, 16'd1});
    cyc(3);
    chk("t2_beat_count", beat_q.size(), 64'd1);
    chk("t2_beat", {23'd0, pop_beat()}, {23'd0, 32'h12345678, 4'd0, 4'd0, 1'b1});

    // 3: backpressure fills the FIFO; tail still accepted.
    out_ready = 1'b0;
    send(mk_hdr(4'd4, 4'd5, 4'd1, 4'd2, 8'd3), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    chk("t3_full_rx_ready", {63'd0, rx_ready}, 64'd0);
    send(mk_tail(4'd4, 4'd5), 1'b0, 1'b1);
    chk("t3_done_ok", {62'd0, pkt_done, pkt_ok}, 64'd3);
    chk("t3_no_beats_yet", beat_q.size(), 64'd0);
    out_ready = 1'b1;
    cyc(6);
    chk("t3_beat_count", beat_q.size(), 64'd4);
    chk("t3_beat0", {23'd0, pop_beat()}, {23'd0, 32'hA0000000, 4'd4, 4'd5, 1'b0});
    chk("t3_beat1", {23'd0, pop_beat()}, {23'd0, 32'hA0000001, 4'd4, 4'd5, 1'b0});
    chk("t3_beat2", {23'd0, pop_beat()}, {23'd0, 32'hA0000002, 4'd4, 4'd5, 1'b0});
    chk("t3_beat3", {23'd0, pop_beat()}, {23'd0, 32'hA0000003, 4'd4, 4'd5, 1'b1});
    chk("t3_counters", {32'd0, pkt_cnt, err_cnt}, {32'd0, 16'd2, 16'd1});

    // 4: overlength packet, third beat dropped.
    send(mk_hdr(4'd2, 4'd2, 4'd1, 4'd2, 8'd1), 1'b1, 1'b0);
    send(32'hB0B0_0001, 1'b0, 1'b0);
    send(32'hB0B0_0002, 1'b0, 1'b0);
    send(32'hB0B0_0003, 1'b0, 1'b0);
    send(mk_tail(4'd2, 4'd2), 1'b0, 1'b1);
    chk("t4_done_ok", {62'd0, pkt_done, pkt_ok}, 64'd2);
    cyc(3);
    chk("t4_beat_count", beat_q.size(), 64'd2);
    chk("t4_beat0", {23'd0, pop_beat()}, {23'd0, 32'hB0B00001, 4'd2, 4'd2, 1'b0});
    chk("t4_beat1", {23'd0, pop_beat()}, {23'd0, 32'hB0B00002, 4'd2, 4'd2, 1'b1});
    chk("t4_counters", {32'd0, pkt_cnt, err_cnt}, {32'd0, 16'd2, 16'd2});

    // Header+tail conflict while idle: dropped silently, following data ignored.
    send(mk_hdr(4'd1, 4'd1, 4'd1, 4'd2, 8'd0), 1'b1, 1'b1);
    chk("conflict_idle_no_pulse", {63'd0, pkt_done}, 64'd0);
    send(32'hCAFE_F00D, 1'b0, 1'b0);
    cyc(3);
    chk("conflict_idle_no_beat", beat_q.size(), 64'd0);

    // 5: lost tail aborts the first packet; the new header starts the second.
    send(mk_hdr(4'd5, 4'd6, 4'd1, 4'd2, 8'd0), 1'b1, 1'b0);
    send(32'h0000_0055, 1'b0, 1'b0);
    send(mk_hdr(4'd7, 4'd7, 4'd1, 4'd2, 8'd0), 1'b1, 1'b0);
    chk("t5_abort", {62'd0, pkt_done, pkt_ok}, 64'd2);
    send(32'h0000_0066, 1'b0, 1'b0);
    send(mk_tail(4'd7, 4'd7), 1'b0, 1'b1);
    chk("t5_done_ok", {62'd0, pkt_done, pkt_ok}, 64'd3);
    chk("t5_counters", {32'd0, pkt_cnt, err_cnt}, {32'd0, 16'd3, 16'd3});
    cyc(3);
    chk("t5_beat_count", beat_q.size(), 64'd2);
    chk("t5_beat0", {23'd0, pop_beat()}, {23'd0, 32'h00000055, 4'd5, 4'd6, 1'b1});
    chk("t5_beat1", {23'd0, pop_beat()}, {23'd0, 32'h00000066, 4'd7, 4'd7, 1'b1});

    // 6: reset mid-packet with beats queued.
    out_ready = 1'b0;
    send(mk_hdr(4'd3, 4'd1, 4'd1, 4'd2, 8'd3), 1'b1, 1'b0);
    send(32'hD000_0001, 1'b0, 1'b0);
    send(32'hD000_0002, 1'b0, 1'b0);
    chk("t6_queued_valid", {63'd0, out_valid}, 64'd1);
    noc_rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_counters", {32'd0, pkt_cnt, err_cnt}, 64'd0);
    cyc(2);
    noc_rst_n = 1'b1;
    out_ready = 1'b1;
    cyc(2);
    send(mk_hdr(4'd9, 4'd8, 4'd1, 4'd2, 8'd0), 1'b1, 1'b0);
    send(32'h7777_1234, 1'b0, 1'b0);
    send(mk_tail(4'd9, 4'd8), 1'b0, 1'b1);
    chk("t6_done_ok", {62'd0, pkt_done, pkt_ok}, 64'd3);
    chk("t6_counters", {32'd0, pkt_cnt, err_cnt}, {32'd0, 16'd1, 16'd0});
    cyc(3);
    chk("t6_beat_count", beat_q.size(), 64'd1);
    chk("t6_beat", {23'd0, pop_beat()}, {23'd0, 32'h77771234, 4'd9, 4'd8, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
